// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants for the memory port arbiter slice.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: the port that did not own the
// memory last wins a tie.
module rr_pick2
  import cpu_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      winner = ~last_owner;
    end else if (req1) begin
      winner = PORT_DMA;
    end else begin
      winner = PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port synchronous memory: one access
// per three cycles, registered command, read data routed back with rvalid.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic                we0,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W/8-1:0] wstrb0,
  input  logic                req1,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic [DATA_W/8-1:0] wstrb1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [DATA_W-1:0]   rdata0,
  output logic [DATA_W-1:0]   rdata1,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t state;
  logic       owner;
  logic       last_owner;
  logic       pick_valid;
  logic       pick_winner;
  logic       grant;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Grants are only offered from IDLE and are masked while reset is held.
  assign grant = (state == IDLE) && pick_valid && !reset;
  assign gnt0  = grant && (pick_winner == PORT_CPU);
  assign gnt1  = grant && (pick_winner == PORT_DMA);

  assign rdata0 = mem_rdata;
  assign rdata1 = mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= PORT_CPU;
      last_owner <= PORT_DMA;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_winner;
            mem_en    <= 1'b1;
            mem_we    <= (pick_winner == PORT_DMA) ? we1    : we0;
            mem_addr  <= (pick_winner == PORT_DMA) ? addr1  : addr0;
            mem_wdata <= (pick_winner == PORT_DMA) ? wdata1 : wdata0;
            mem_wstrb <= (pick_winner == PORT_DMA) ? wstrb1 : wstrb0;
            state     <= ISSUE;
          end
        end
        // --- ISSUE -> RESP: memory samples the command at this edge
        ISSUE: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          rvalid0 <= (owner == PORT_CPU);
          rvalid1 <= (owner == PORT_DMA);
          state   <= RESP;
        end
        // --- RESP -> IDLE: read data is on mem_rdata during RESP
        RESP: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [STRB_W-1:0] unused_strb_w;
  assign unused_strb_w = '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single-port synchronous memory between two requesters: port 0 (the multicycle core's fetch/load/store port) and port 1 (the boot loader / debug DMA port). The block sits between the core's memory-address mux and the memory macro. It grants one access at a time with round-robin priority, registers the command into the memory, and routes the one-cycle-latency read data back to the owner with a valid strobe.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; write strobe width is DATA_W/8
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- req0 / req1  in  1  access request from port 0 / 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  byte address
- wdata0 / wdata1  in  DATA_W  write data
- wstrb0 / wstrb1  in  DATA_W/8  byte enables for writes
- gnt0 / gnt1  out  1  request accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  access complete; read data valid on rdata
- rdata0 / rdata1  out  DATA_W  read data, driven from mem_rdata, meaningful only with rvalid
- mem_en  out  1  memory access enable (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDR_W  memory byte address (registered)
- mem_wdata  out  DATA_W  (registered)
- mem_wstrb  out  DATA_W/8  (registered)
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en

## Operation
- FSM states:
  - IDLE
  - ISSUE
  - RESP
- IDLE: if any req, pick a winner and assert its gnt. Latch the winner's we/addr/wdata/wstrb into the mem_* registers. Set mem_en=1 and record the owner. Go to ISSUE. With no req, stay in IDLE.
- ISSUE: mem_en=1 for exactly this cycle. At the edge, clear mem_en and mem_we, then go to RESP.
- RESP: assert rvalid for the owner only, with rdata = mem_rdata. Set last_owner = owner, then go to IDLE.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the port that is not last_owner wins.
  - last_owner resets to 1, so port 0 wins the first contention.
- gnt is asserted only in IDLE and to at most one port. gnt0 and gnt1 are never both high.
- Requester rules:
  - Hold req/we/addr/wdata/wstrb stable until gnt.
  - Drop req the cycle after gnt unless issuing a new access.
  - A req held through ISSUE/RESP is re-arbitrated in the next IDLE.
- Writes also produce rvalid (completion). rdata is don't-care on write completion.
- rdata0 and rdata1 both mirror mem_rdata at all times. Only the owner's rvalid qualifies it.
- mem_addr is passed through as a byte address with no alignment check. The memory ignores addr[1:0].

## Timing
- Reset values:
  - state = IDLE
  - last_owner = 1
  - gnt0 = gnt1 = 0
  - rvalid0 = rvalid1 = 0
  - mem_en = 0, mem_we = 0
  - mem_addr = 0, mem_wdata = 0, mem_wstrb = 0
- Sequence for a grant in cycle N:
  - N: gnt high
  - N+1: mem_en high (ISSUE)
  - N+2: rvalid high, mem_rdata valid (RESP)
  - N+3: earliest next gnt
- Throughput is one access per 3 cycles. Grant-to-rvalid latency is 2 cycles.
- Simultaneous req0 and req1 in IDLE: exactly one gnt, per round-robin. Under continuous contention, grants alternate 0, 1, 0, 1.
- A req that arrives in ISSUE or RESP is not granted until the next IDLE cycle.
- Reset mid-operation (ISSUE or RESP):
  - Return to IDLE immediately.
  - mem_en and mem_we go low asynchronously.
  - The in-flight access produces no rvalid. Requesters re-issue.
- mem_we is never high without mem_en.

## Structure
- Shared package cpu_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, ISSUE, RESP}
  - constants PORT_CPU = 1'b0 and PORT_DMA = 1'b1
- Sub-module rr_pick2: a combinational 2-way round-robin picker.
  - Inputs: req0, req1, last_owner.
  - Outputs: valid, winner.
  - Instantiated once.
- The FSM, command registers and owner/last_owner flops live in the top module.

## Test plan
- Post-reset single read: req0=1, we0=0, addr0=0x100, memory holds 0xDEADBEEF → gnt0 in cycle 0, mem_en/mem_addr=0x100 in cycle 1, rvalid0=1 with rdata0=0xDEADBEEF in cycle 2, rvalid1 stays 0.
- Port 1 write: req1=1, we1=1, addr1=0x20, wdata1=0x12345678, wstrb1=4'b0011 → mem_en=mem_we=1 with those values for exactly one cycle. rvalid1 follows one cycle later. A read-back through port 0 returns 0x????5678 in the low half.
- Contention: req0=req1=1 held for 4 accesses from reset → grant order 0,1,0,1. Grants occur 3 cycles apart. gnt0 and gnt1 are never high together.
- Late request: req1 raised during port 0's ISSUE cycle → no gnt1 until port 0's RESP completes. gnt1 comes in the following IDLE cycle.
- Reset during ISSUE of a write: mem_en and mem_we drop with reset, no rvalid, state=IDLE. The first post-reset contention goes to port 0.
- Idle hold: no req for 10 cycles → mem_en=0, gnt=0, rvalid=0 throughout, mem_* registers unchanged.
